best_d_seq: RTL and testbench

- Parametrised, handshaked successor of the power-of-two block-size selector.
- Per request, maps error weight t to a fixed-point factor theta, then forms p = n*theta with a bit-serial shift-add multiplier. It scales q = p >> FRAC and returns the power of two d = 2^u that brackets q.
- New versus the previous generation: selectable ceil/floor rounding, a clamp to a parametrised maximum exponent with a saturation flag, and a valid/ready handshake on both sides.
- Sits ahead of the signature-generation datapath that consumes d and u.

---
 rtl/best_d_seq.sv | 175 +++++++++++++++++
 tb/tb_best_d_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/best_d_seq.sv
// ----------------------------------------------------------------------------
// best_d_seq
//
// Per-request block-size selector. Each accepted request maps the error
// weight t to a fixed-point factor theta, forms p = n * theta with a
// bit-serial shift-add multiplier (one theta bit per cycle, LSB first),
// scales q = p >> FRAC and returns the power of two d = 2^u that brackets q.
// Rounding is ceil (smallest 2^u >= q) or floor (largest 2^u <= q). The
// exponent is clamped to UMAX, and sat reports that the clamp was applied.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   request valid
//   in_ready   request can be accepted (high only while idle)
//   n          code length, sampled on accept
//   t          error weight, sampled on accept
//   mode       0 = ceil, 1 = floor, sampled on accept
//   out_valid  result valid; held until out_ready
//   out_ready  consumer accepts the result
//   d          chosen block size, 2^u
//   u          log2 of d
//   q          scaled product (n * theta) >> FRAC
//   sat        the unclamped exponent exceeded UMAX
// ----------------------------------------------------------------------------
module best_d_seq #(
    parameter int N_W     = 13,
    parameter int T_W     = 5,
    parameter int THETA_W = 5,
    parameter int FRAC    = 5,
    parameter int UMAX    = 12,
    parameter int U_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_W-1:0]              n,
    input  logic [T_W-1:0]              t,
    input  logic                        mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_W-1:0]              d,
    output logic [U_W-1:0]              u,
    output logic [N_W+THETA_W-FRAC-1:0] q,
    output logic                        sat
);

    localparam int ACC_W = N_W + THETA_W;
    localparam int Q_W   = N_W + THETA_W - FRAC;
    localparam int CNT_W = (THETA_W > 1) ? $clog2(THETA_W) : 1;
    // Wide enough for the unclamped exponent (at most Q_W) plus headroom.
    localparam int UR_W  = $clog2(Q_W + 1) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ENC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THETA_W - 1);

    logic [1:0]         state;
    logic [N_W-1:0]     n_r;
    logic               mode_r;
    logic [THETA_W-1:0] theta_r;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic [Q_W-1:0]     q_c;
    logic [UR_W-1:0]    u_raw;
    logic [U_W-1:0]     u_c;
    logic               sat_c;

    // Error weight to theta (in units of 2^-FRAC).
    function automatic logic [THETA_W-1:0] theta_of(input logic [T_W-1:0] tv);
        int ti;
        ti = int'(tv);
        if      (ti >= 11) theta_of = THETA_W'(1);
        else if (ti >= 8)  theta_of = THETA_W'(2);
        else if (ti >= 6)  theta_of = THETA_W'(3);
        else if (ti == 5)  theta_of = THETA_W'(4);
        else if (ti == 4)  theta_of = THETA_W'(5);
        else if (ti == 3)  theta_of = THETA_W'(6);
        else if (ti == 2)  theta_of = THETA_W'(9);
        else               theta_of = THETA_W'(16);
    endfunction

    // Index of the most significant set bit; 0 for a zero input.
    function automatic logic [UR_W-1:0] msb_idx(input logic [Q_W-1:0] v);
        msb_idx = '0;
        for (int i = 0; i < Q_W; i++) begin
            if (v[i]) msb_idx = UR_W'(i);
        end
    endfunction

    assign in_ready = (state == S_IDLE);

    // Exponent encoder, evaluated from the finished accumulator in ENC.
    // NOTE: every variable gets a value on every path through always_comb,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        q_c = Q_W'(acc >> FRAC);
        if (mode_r) begin
            u_raw = msb_idx(q_c);
        end else if (q_c <= Q_W'(1)) begin
            u_raw = '0;
        end else begin
            // Ceil: a non-power-of-two q rounds up; subtracting one first
            // keeps an exact power of two from being pushed one step higher.
            u_raw = msb_idx(q_c - Q_W'(1)) + UR_W'(1);
        end
        sat_c = (u_raw > UR_W'(UMAX));
        u_c   = sat_c ? U_W'(UMAX) : U_W'(u_raw);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset along with control so that
            // outputs read a defined d=1/u=0 and an aborted product is dropped.
            state     <= S_IDLE;
            n_r       <= '0;
            mode_r    <= 1'b0;
            theta_r   <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            d         <= N_W'(1);
            u         <= '0;
            q         <= '0;
            sat       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        n_r     <= n;
                        mode_r  <= mode;
                        theta_r <= theta_of(t);
                        acc     <= '0;
                        cnt     <= '0;
                        state   <= S_MUL;
                    end
                end
                S_MUL: begin
                    // One partial product per cycle; ACC_W bits cannot overflow.
                    if (theta_r[cnt]) begin
                        acc <= acc + (ACC_W'(n_r) << cnt);
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= S_ENC;
                    end
                end
                S_ENC: begin
                    d         <= N_W'(1) << u_c;
                    u         <= u_c;
                    q         <= q_c;
                    sat       <= sat_c;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    // d/u/q/sat stay as registered after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_best_d_seq.sv
// ----------------------------------------------------------------------------
// tb_best_d_seq
//
// Self-checking bench for best_d_seq. Two instances share all inputs: one
// with default parameters and one with UMAX=10 to exercise saturation. The
// reference model computes q = (n * theta) / 2^FRAC and searches for the
// bracketing power of two with plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_best_d_seq;

    localparam int N_W = 13;
    localparam int T_W = 5;
    localparam int U_W = 4;
    localparam int Q_W = 13;
    localparam int R_W = N_W + U_W + Q_W + 1;
    localparam int LAT = 6;
    localparam int PERIOD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           in_valid;
    logic [N_W-1:0] n;
    logic [T_W-1:0] t;
    logic           mode;
    logic           out_ready;

    logic           in_ready_a, out_valid_a, sat_a;
    logic [N_W-1:0] d_a;
    logic [U_W-1:0] u_a;
    logic [Q_W-1:0] q_a;
    logic           in_ready_b, out_valid_b, sat_b;
    logic [N_W-1:0] d_b;
    logic [U_W-1:0] u_b;
    logic [Q_W-1:0] q_b;

    logic [R_W-1:0] res_a, res_b;
    assign res_a = {d_a, u_a, q_a, sat_a};
    assign res_b = {d_b, u_b, q_b, sat_b};

    int n_checks = 0;
    int n_fail   = 0;

    best_d_seq dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .n(n), .t(t), .mode(mode), .out_valid(out_valid_a), .out_ready(out_ready),
        .d(d_a), .u(u_a), .q(q_a), .sat(sat_a)
    );

    best_d_seq #(.UMAX(10)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .n(n), .t(t), .mode(mode), .out_valid(out_valid_b), .out_ready(out_ready),
        .d(d_b), .u(u_b), .q(q_b), .sat(sat_b)
    );

    typedef struct {
        int n;
        int t;
        int md;
        int ed;
        int eu;
    } vec_t;

    // Directed cases with hand-derived d/u for the default instance.
    vec_t vecs [7] = '{
        '{4900, 18, 0,  256,  8},
        '{1000,  2, 0,  512,  9},
        '{1000,  2, 1,  256,  8},
        '{  40, 18, 0,    1,  0},
        '{  64, 18, 0,    2,  1},
        '{8191,  0, 0, 4096, 12},
        '{8191,  0, 1, 2048, 11}
    };

    function automatic int theta_of(int tt);
        if (tt >= 11)     return 1;
        else if (tt >= 8) return 2;
        else if (tt >= 6) return 3;
        else if (tt == 5) return 4;
        else if (tt == 4) return 5;
        else if (tt == 3) return 6;
        else if (tt == 2) return 9;
        else              return 16;
    endfunction

    // Expected {d, u, q, sat} for a request on an instance with the given umax.
    function automatic logic [R_W-1:0] model(int nn, int tt, int md, int umax);
        int   qq;
        int   uu;
        logic s;
        qq = (nn * theta_of(tt)) / 32;
        uu = 0;
        if (md == 0) begin
            while ((1 << uu) < qq) uu++;
        end else begin
            while ((2 << uu) <= qq) uu++;
        end
        s = (uu > umax);
        if (s) uu = umax;
        return {N_W'(1 << uu), U_W'(uu), Q_W'(qq), s};
    endfunction

    // Offer one request (expects in_ready=1 on entry), then scramble the
    // inputs and wait a bounded time for out_valid.
    task automatic do_request(input int nn, input int tt, input int md,
                              output int lat, output bit saw_ready);
        n        = N_W'(nn);
        t        = T_W'(tt);
        mode     = md[0];
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        n         = N_W'($urandom);
        t         = T_W'($urandom);
        mode      = 1'($urandom);
        lat       = 0;
        saw_ready = 1'b0;
        while (!out_valid_a && lat < 30) begin
            if (in_ready_a) saw_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready_a) saw_ready = 1'b1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n         = '0;
        t         = '0;
        mode      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || res_a !== {N_W'(1), U_W'(0), Q_W'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL reset_a: got rdy=%b vld=%b res=%h want rdy=1 vld=0 d=1 u=0 q=0 sat=0",
                     in_ready_a, out_valid_a, res_a);
        end
        n_checks++;
        if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || res_b !== {N_W'(1), U_W'(0), Q_W'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL reset_b: got rdy=%b vld=%b res=%h", in_ready_b, out_valid_b, res_b);
        end
    endtask

    task automatic test_directed();
        int lat;
        bit saw_ready;
        logic [R_W-1:0] want_a, want_b;
        foreach (vecs[i]) begin
            want_a = model(vecs[i].n, vecs[i].t, vecs[i].md, 12);
            want_b = model(vecs[i].n, vecs[i].t, vecs[i].md, 10);
            do_request(vecs[i].n, vecs[i].t, vecs[i].md, lat, saw_ready);
            n_checks++;
            if (lat != LAT || saw_ready) begin
                n_fail++;
                $display("FAIL directed%0d_timing: got lat=%0d ready_seen=%b want lat=%0d ready_seen=0",
                         i, lat, saw_ready, LAT);
            end
            n_checks++;
            if (int'(d_a) != vecs[i].ed || int'(u_a) != vecs[i].eu || res_a !== want_a) begin
                n_fail++;
                $display("FAIL directed%0d_a: got d=%0d u=%0d q=%0d sat=%b want d=%0d u=%0d res=%h",
                         i, d_a, u_a, q_a, sat_a, vecs[i].ed, vecs[i].eu, want_a);
            end
            n_checks++;
            if (out_valid_b !== 1'b1 || res_b !== want_b) begin
                n_fail++;
                $display("FAIL directed%0d_b: got vld=%b d=%0d u=%0d q=%0d sat=%b want res=%h",
                         i, out_valid_b, d_b, u_b, q_b, sat_b, want_b);
            end
            release_out();
        end
    endtask

    task automatic test_random();
        int lat;
        bit saw_ready;
        int nn, tt, md;
        logic [R_W-1:0] want_a, want_b;
        for (int i = 0; i < 20; i++) begin
            nn = int'($urandom_range(0, 8191));
            tt = int'($urandom_range(0, 31));
            md = int'($urandom_range(0, 1));
            want_a = model(nn, tt, md, 12);
            want_b = model(nn, tt, md, 10);
            do_request(nn, tt, md, lat, saw_ready);
            n_checks++;
            if (lat != LAT || res_a !== want_a || res_b !== want_b) begin
                n_fail++;
                $display("FAIL random%0d n=%0d t=%0d mode=%0d: got lat=%0d a=%h b=%h want lat=%0d a=%h b=%h",
                         i, nn, tt, md, lat, res_a, res_b, LAT, want_a, want_b);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit saw_ready;
        logic [R_W-1:0] held_a, held_b, want_a;
        do_request(3000, 7, 1, lat, saw_ready);
        want_a = model(3000, 7, 1, 12);
        n_checks++;
        if (lat != LAT || res_a !== want_a) begin
            n_fail++;
            $display("FAIL bp_first: got lat=%0d res=%h want lat=%0d res=%h", lat, res_a, LAT, want_a);
        end
        held_a = res_a;
        held_b = res_b;
        // A competing request is offered while the result is stalled.
        n        = N_W'(100);
        t        = T_W'(1);
        mode     = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (res_a !== held_a || res_b !== held_b || out_valid_a !== 1'b1 || in_ready_a !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got res=%h vld=%b rdy=%b want res=%h vld=1 rdy=0",
                         c, res_a, out_valid_a, in_ready_a, held_a);
            end
        end
        release_out();
        n_checks++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || res_a !== held_a) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy=%b res=%h want vld=0 rdy=1 res=%h",
                     out_valid_a, in_ready_a, res_a, held_a);
        end
        do_request(100, 1, 0, lat, saw_ready);
        want_a = model(100, 1, 0, 12);
        n_checks++;
        if (lat != LAT || res_a !== want_a || int'(d_a) != 64) begin
            n_fail++;
            $display("FAIL bp_next: got lat=%0d d=%0d res=%h want lat=%0d d=64 res=%h",
                     lat, d_a, res_a, LAT, want_a);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit saw_ready;
        bit early;
        logic [R_W-1:0] want_a;
        n        = N_W'(5000);
        t        = T_W'(5);
        mode     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;          // accept edge; MUL cycle 1 follows
        in_valid = 1'b0;
        @(posedge clk); #1;          // MUL cycle 2
        @(posedge clk); #1;          // MUL cycle 3
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || res_a !== {N_W'(1), U_W'(0), Q_W'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: got rdy=%b vld=%b res=%h want rdy=1 vld=0 d=1 u=0 q=0 sat=0",
                     in_ready_a, out_valid_a, res_a);
        end
        early = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            if (out_valid_a || !in_ready_a) early = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL reset_mid_discard: got stray activity=1 want 0");
        end
        do_request(4900, 18, 0, lat, saw_ready);
        want_a = model(4900, 18, 0, 12);
        n_checks++;
        if (lat != LAT || int'(d_a) != 256 || res_a !== want_a) begin
            n_fail++;
            $display("FAIL reset_mid_after: got lat=%0d d=%0d res=%h want lat=%0d d=256 res=%h",
                     lat, d_a, res_a, LAT, want_a);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [R_W-1:0] q_exp_a[$];
        logic [R_W-1:0] q_exp_b[$];
        logic [R_W-1:0] want_a, want_b;
        int pushed = 0;
        int got = 0;
        int last = -1;
        int nn, tt, md;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
            if (out_valid_a) begin
                want_a = (q_exp_a.size() > 0) ? q_exp_a.pop_front() : '0;
                want_b = (q_exp_b.size() > 0) ? q_exp_b.pop_front() : '0;
                n_checks++;
                if (res_a !== want_a || res_b !== want_b || (last >= 0 && cyc - last != PERIOD)) begin
                    n_fail++;
                    $display("FAIL b2b%0d: got a=%h b=%h gap=%0d want a=%h b=%h gap=%0d",
                             got, res_a, res_b, cyc - last, want_a, want_b, PERIOD);
                end
                last = cyc;
                got++;
            end
            if (in_ready_a) begin
                if (pushed < 4) begin
                    nn = int'($urandom_range(0, 8191));
                    tt = int'($urandom_range(0, 31));
                    md = int'($urandom_range(0, 1));
                    n    = N_W'(nn);
                    t    = T_W'(tt);
                    mode = md[0];
                    in_valid = 1'b1;
                    q_exp_a.push_back(model(nn, tt, md, 12));
                    q_exp_b.push_back(model(nn, tt, md, 10));
                    pushed++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                // Values offered while busy must not leak into any result.
                n = N_W'($urandom);
                t = T_W'($urandom);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results want 4", got);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
